// File: rtl/mealy_frame_tx.sv
// Bit-serial frame transmitter: preamble, data word MSB-first, even parity, idle gap.
// One word is accepted per tx_valid/tx_ready handshake while the block is idle.
module mealy_frame_tx #(
    parameter int               DATA_W       = 8,
    parameter int               PRE_W        = 4,
    parameter logic [PRE_W-1:0] PREAMBLE     = 4'b1011,
    parameter int               CLKS_PER_BIT = 1,
    parameter int               GAP_BITS     = 2,
    parameter logic             IDLE_LEVEL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    output logic              bit_strobe,
    output logic              frame_start,
    output logic              busy,
    output logic              done
);

    localparam int MAX_DP   = (DATA_W > PRE_W) ? DATA_W : PRE_W;
    localparam int MAX_BITS = (MAX_DP > GAP_BITS) ? MAX_DP : GAP_BITS;
    localparam int BCW      = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int CCW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BCW-1:0] PRE_LAST  = BCW'(PRE_W - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] GAP_LAST  = BCW'(GAP_BITS - 1);
    localparam logic [CCW-1:0] CLK_LAST  = CCW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_PAR  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t            state;
    logic [BCW-1:0]    bit_cnt;
    logic [CCW-1:0]    clk_cnt;
    logic [DATA_W-1:0] shreg;
    logic [PRE_W-1:0]  pre_sr;
    logic              par;

    assign tx_ready = (state == S_IDLE) && !rst;

    // Outputs describe the bit on the wire in the current cycle; counters index that bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            clk_cnt     <= '0;
            shreg       <= '0;
            pre_sr      <= '0;
            par         <= 1'b0;
            ser_out     <= IDLE_LEVEL;
            bit_strobe  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    bit_strobe <= 1'b0;
                    ser_out    <= IDLE_LEVEL;
                    if (tx_valid && tx_ready) begin
                        state       <= S_PRE;
                        shreg       <= tx_data;
                        par         <= ^tx_data;
                        pre_sr      <= PREAMBLE << 1;
                        bit_cnt     <= '0;
                        clk_cnt     <= '0;
                        ser_out     <= PREAMBLE[PRE_W-1];
                        bit_strobe  <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    if (clk_cnt != CLK_LAST) begin
                        clk_cnt    <= clk_cnt + CCW'(1);
                        bit_strobe <= 1'b0;
                    end else begin
                        // Bit boundary: select the next bit and restart the divider.
                        clk_cnt    <= '0;
                        bit_strobe <= 1'b1;
                        case (state)
                            S_PRE: begin
                                if (bit_cnt == PRE_LAST) begin
                                    state   <= S_DATA;
                                    bit_cnt <= '0;
                                    ser_out <= shreg[DATA_W-1];
                                    shreg   <= shreg << 1;
                                end else begin
                                    bit_cnt <= bit_cnt + BCW'(1);
                                    ser_out <= pre_sr[PRE_W-1];
                                    pre_sr  <= pre_sr << 1;
                                end
                            end
                            S_DATA: begin
                                if (bit_cnt == DATA_LAST) begin
                                    state   <= S_PAR;
                                    bit_cnt <= '0;
                                    ser_out <= par;
                                end else begin
                                    bit_cnt <= bit_cnt + BCW'(1);
                                    ser_out <= shreg[DATA_W-1];
                                    shreg   <= shreg << 1;
                                end
                            end
                            S_PAR: begin
                                state   <= S_GAP;
                                bit_cnt <= '0;
                                ser_out <= IDLE_LEVEL;
                            end
                            S_GAP: begin
                                ser_out <= IDLE_LEVEL;
                                if (bit_cnt == GAP_LAST) begin
                                    state      <= S_IDLE;
                                    bit_cnt    <= '0;
                                    bit_strobe <= 1'b0;
                                    busy       <= 1'b0;
                                    done       <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + BCW'(1);
                                end
                            end
                            default: begin
                                state      <= S_IDLE;
                                bit_cnt    <= '0;
                                bit_strobe <= 1'b0;
                                busy       <= 1'b0;
                                ser_out    <= IDLE_LEVEL;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_frame_tx.sv
// Bench for mealy_frame_tx: one instance at default timing, one at three clocks per bit.
// Expected frames are hand-written 15-bit patterns; a monitor pops them on every bit_strobe.
module tb_mealy_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data     [2];
    logic       tx_valid    [2];
    logic       tx_ready    [2];
    logic       ser_out     [2];
    logic       bit_strobe  [2];
    logic       frame_start [2];
    logic       busy        [2];
    logic       done        [2];

    // Entry = {frame_start, ser_out} expected on a strobe cycle.
    logic [1:0] exp_q[$];
    logic       held [2];
    logic [1:0] e;

    int n_cmp  = 0;
    int n_fail = 0;

    mealy_frame_tx dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .ser_out(ser_out[0]), .bit_strobe(bit_strobe[0]), .frame_start(frame_start[0]),
        .busy(busy[0]), .done(done[0])
    );

    mealy_frame_tx #(.CLKS_PER_BIT(3)) dut3 (
        .clk(clk), .rst(rst),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .ser_out(ser_out[1]), .bit_strobe(bit_strobe[1]), .frame_start(frame_start[1]),
        .busy(busy[1]), .done(done[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // monitor
    initial begin
        held[0] = 1'b0;
        held[1] = 1'b0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bit_strobe[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bit", {30'd0, frame_start[i], ser_out[i]}, {30'd0, e});
                    held[i] = e[0];
                end
            end else begin
                chk("hold", {30'd0, frame_start[i], ser_out[i]},
                    {31'd0, (busy[i] === 1'b1) ? held[i] : 1'b0});
            end
        end
    end

    // driver
    task automatic push_frame(input logic [14:0] frame);
        for (int b = 14; b >= 0; b--) exp_q.push_back({(b == 14) ? 1'b1 : 1'b0, frame[b]});
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic [14:0] frame,
                        input int cpb, input bit hold);
        int len;
        int w;
        len = 15 * cpb;
        w = 0;
        while (tx_ready[i] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (tx_ready[i] !== 1'b1) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            tx_data[i]  = d;
            tx_valid[i] = 1'b1;
            @(posedge clk);
            push_frame(frame);
            #1;
            if (!hold) tx_valid[i] = 1'b0;
            tx_data[i] = d ^ 8'h5A;
            for (int k = 1; k <= len + 1; k++) begin
                @(negedge clk);
                if (k == 4) tx_data[i] = ~d;
                chk("busy", {31'd0, busy[i]}, {31'd0, (k <= len) ? 1'b1 : 1'b0});
                chk("done", {31'd0, done[i]}, {31'd0, (k == len + 1) ? 1'b1 : 1'b0});
                chk("tx_ready", {31'd0, tx_ready[i]}, {31'd0, (k == len + 1) ? 1'b1 : 1'b0});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tx_data[i]  = 8'h00;
            tx_valid[i] = 1'b0;
        end
        tx_valid[0] = 1'b1;

        // T1 reset held with a pending word
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", {31'd0, tx_ready[0]}, 32'd0);
            chk("rst_busy", {31'd0, busy[0]}, 32'd0);
            chk("rst_done", {31'd0, done[0]}, 32'd0);
            chk("rst_ready3", {31'd0, tx_ready[1]}, 32'd0);
        end
        rst = 1'b0;
        tx_valid[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, tx_ready[0]}, 32'd1);
        chk("post_rst_ready3", {31'd0, tx_ready[1]}, 32'd1);
        chk("post_rst_busy", {31'd0, busy[0]}, 32'd0);

        // T2 / T3 single frames
        send(0, 8'hA5, 15'b1011_10100101_0_00, 1, 1'b0);
        send(0, 8'h01, 15'b1011_00000001_1_00, 1, 1'b0);
        send(0, 8'hFF, 15'b1011_11111111_0_00, 1, 1'b0);
        send(0, 8'h07, 15'b1011_00000111_1_00, 1, 1'b0);
        repeat (3) @(negedge clk);

        // T4 three clocks per bit
        send(1, 8'h80, 15'b1011_10000000_1_00, 3, 1'b0);
        repeat (3) @(negedge clk);

        // T5 back-to-back with tx_valid held high
        send(0, 8'h3C, 15'b1011_00111100_0_00, 1, 1'b1);
        send(0, 8'hC3, 15'b1011_11000011_0_00, 1, 1'b0);
        repeat (3) @(negedge clk);

        // T6 reset in the middle of the data field
        tx_data[0]  = 8'h5A;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        push_frame(15'b1011_01011010_0_00);
        #1;
        tx_valid[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ser", {31'd0, ser_out[0]}, 32'd0);
        chk("abort_busy", {31'd0, busy[0]}, 32'd0);
        chk("abort_done", {31'd0, done[0]}, 32'd0);
        chk("abort_ready", {31'd0, tx_ready[0]}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (20) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done[0]}, 32'd0);
            chk("abort_idle", {31'd0, busy[0]}, 32'd0);
            chk("abort_ready_back", {31'd0, tx_ready[0]}, 32'd1);
        end
        send(0, 8'h96, 15'b1011_10010110_0_00, 1, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
